// File: rtl/uart_tft_pkg.sv
// Shared definitions for the UART pixel loader: RX FSM state encoding and
// a constant-evaluable ceiling-log2 helper.
// Optional feature macro: UART_PARITY_EN (adds an even-parity bit state).
package uart_tft_pkg;

`ifdef UART_PARITY_EN
    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4
    } rx_state_t;
`else
    typedef enum logic [2:0] {
        RX_IDLE  = 3'd0,
        RX_START = 3'd1,
        RX_DATA  = 3'd2,
        RX_STOP  = 3'd3
    } rx_state_t;
`endif

    // Bits needed to address v distinct values; never less than 1.
    function automatic int clog2(input longint v);
        int r;
        r = 0;
        while ((longint'(1) << r) < v) r = r + 1;
        if (r == 0) r = 1;
        return r;
    endfunction

endpackage

// File: rtl/uart_pixel_loader_if.sv
// Pixel write-side bus of the UART pixel loader: RAM write strobe, address,
// assembled pixel, end-of-frame pulse and discarded-byte pulse.
interface uart_pixel_loader_if #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 16
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              frame_done;
    logic              rx_err;

    modport master (output wr_en, output wr_addr, output wr_data,
                    output frame_done, output rx_err);
    modport slave  (input wr_en, input wr_addr, input wr_data,
                    input frame_done, input rx_err);
endinterface

// File: rtl/uart_byte_rx.sv
// UART byte receiver: 2-FF synchronizer, start-bit glitch rejection,
// 8 data bits LSB first, stop-bit check. byte_valid/byte_err are single-cycle
// pulses in the stop-sample cycle; byte_data is valid with byte_valid.
// Optional feature macro: UART_PARITY_EN (even parity bit before stop).
module uart_byte_rx
    import uart_tft_pkg::*;
#(
    parameter int BAUD_DIV = 434
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       uart_rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       byte_err,
    output logic       rx_idle
);
    localparam int HALF = BAUD_DIV / 2;
    localparam int CW   = clog2(BAUD_DIV + 1);

    logic      r_sync1, r_sync2, r_prev;
    rx_state_t r_state, w_state_nxt;
    logic [CW-1:0] r_baud, w_baud_nxt;
    logic [2:0] r_bit, w_bit_nxt;
    logic [7:0] r_shift, w_shift_nxt;
    logic w_fall;
`ifdef UART_PARITY_EN
    logic r_par_ok, w_par_ok_nxt;
`endif

    assign w_fall    = r_prev & ~r_sync2;
    assign byte_data = r_shift;
    assign rx_idle   = (r_state == RX_IDLE);

    // Synchronize the line (idle high) and keep one extra stage for edge detect.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
        end else begin
            r_sync1 <= uart_rx;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    // RX FSM state and bit-timing registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= RX_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
`ifdef UART_PARITY_EN
            r_par_ok <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_baud  <= w_baud_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
`ifdef UART_PARITY_EN
            r_par_ok <= w_par_ok_nxt;
`endif
        end
    end

    // RX FSM next state, sampling and byte result pulses.
    always_comb begin
        w_state_nxt = r_state;
        w_baud_nxt  = r_baud + CW'(1);
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        byte_valid  = 1'b0;
        byte_err    = 1'b0;
`ifdef UART_PARITY_EN
        w_par_ok_nxt = r_par_ok;
`endif
        case (r_state)
            RX_IDLE: begin
                w_baud_nxt = '0;
                if (w_fall) w_state_nxt = RX_START;
            end
            RX_START: begin
                // Mid start bit: a high line here was only a glitch.
                if (r_baud == CW'(HALF - 1)) begin
                    w_baud_nxt  = '0;
                    w_bit_nxt   = '0;
                    w_state_nxt = r_sync2 ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (r_baud == CW'(BAUD_DIV - 1)) begin
                    w_baud_nxt  = '0;
                    w_shift_nxt = {r_sync2, r_shift[7:1]};
                    w_bit_nxt   = r_bit + 3'd1;
                    if (r_bit == 3'd7) begin
`ifdef UART_PARITY_EN
                        w_state_nxt = RX_PARITY;
`else
                        w_state_nxt = RX_STOP;
`endif
                    end
                end
            end
`ifdef UART_PARITY_EN
            RX_PARITY: begin
                if (r_baud == CW'(BAUD_DIV - 1)) begin
                    w_baud_nxt   = '0;
                    w_par_ok_nxt = ((^r_shift) == r_sync2);
                    w_state_nxt  = RX_STOP;
                end
            end
`endif
            RX_STOP: begin
                if (r_baud == CW'(BAUD_DIV - 1)) begin
                    w_baud_nxt  = '0;
                    w_state_nxt = RX_IDLE;
`ifdef UART_PARITY_EN
                    if (r_sync2 && r_par_ok) byte_valid = 1'b1;
`else
                    if (r_sync2) byte_valid = 1'b1;
`endif
                    else byte_err = 1'b1;
                end
            end
            default: w_state_nxt = RX_IDLE;
        endcase
    end

endmodule

// File: rtl/uart_pixel_loader.sv
// UART pixel loader: assembles BYTES_PER_PIX received bytes (first byte most
// significant) into a pixel and writes it to sequential RAM addresses,
// wrapping at the end of the frame. A long idle gap drops a partial pixel.
// Optional feature macro: UART_PARITY_EN (handled in uart_byte_rx).
module uart_pixel_loader
    import uart_tft_pkg::*;
#(
    parameter int CLK_FREQ      = 50000000,
    parameter int BAUD          = 115200,
    parameter int BYTES_PER_PIX = 2,
    parameter int H_PIX         = 480,
    parameter int V_PIX         = 272,
    parameter int GAP_BITS      = 32
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                uart_rx,
    uart_pixel_loader_if.master pix
);
    localparam int BAUD_DIV = CLK_FREQ / BAUD;
    localparam int NPIX     = H_PIX * V_PIX;
    localparam int ADDR_W   = clog2(NPIX);
    localparam int DATA_W   = 8 * BYTES_PER_PIX;
    localparam int GAP_CYC  = GAP_BITS * BAUD_DIV;
    localparam int GAP_W    = clog2(GAP_CYC + 1);

    logic              w_byte_valid, w_byte_err, w_rx_idle, w_gap_expired;
    logic [7:0]        w_byte_data;
    logic [DATA_W-1:0] w_next_pix;
    logic [DATA_W-1:0] r_pix, r_wr_data;
    logic [ADDR_W-1:0] r_addr;
    logic [1:0]        r_cnt;
    logic [GAP_W-1:0]  r_gap;
    logic              r_wr_en, r_frame_done, r_rx_err;

    uart_byte_rx #(.BAUD_DIV(BAUD_DIV)) u_rx (
        .Clk        (Clk),
        .Reset      (Reset),
        .uart_rx    (uart_rx),
        .byte_valid (w_byte_valid),
        .byte_data  (w_byte_data),
        .byte_err   (w_byte_err),
        .rx_idle    (w_rx_idle)
    );

    // Older bytes shift toward the MSB; the oldest falls off the top.
    assign w_next_pix    = DATA_W'({r_pix, w_byte_data});
    assign w_gap_expired = w_rx_idle && (r_cnt != 2'd0) &&
                           (r_gap == GAP_W'(GAP_CYC - 1));

    // Pixel assembly, write strobe, address sequencing and error pulse.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_wr_en      <= 1'b0;
            r_frame_done <= 1'b0;
            r_rx_err     <= 1'b0;
            r_addr       <= '0;
            r_wr_data    <= '0;
            r_pix        <= '0;
            r_cnt        <= 2'd0;
        end else begin
            r_wr_en      <= 1'b0;
            r_frame_done <= 1'b0;
            r_rx_err     <= w_byte_err;
            if (r_wr_en)
                r_addr <= (r_addr == ADDR_W'(NPIX - 1)) ? '0 : r_addr + ADDR_W'(1);
            if (w_byte_valid) begin
                r_pix <= w_next_pix;
                if (r_cnt == 2'(BYTES_PER_PIX - 1)) begin
                    r_cnt        <= 2'd0;
                    r_wr_en      <= 1'b1;
                    r_wr_data    <= w_next_pix;
                    r_frame_done <= (r_addr == ADDR_W'(NPIX - 1));
                end else begin
                    r_cnt <= r_cnt + 2'd1;
                end
            end else if (w_gap_expired) begin
                r_cnt <= 2'd0;
            end
        end
    end

    // Idle-gap timer: runs only while the receiver idles with a partial pixel.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_gap <= '0;
        end else if (!w_rx_idle || (r_cnt == 2'd0) || w_gap_expired) begin
            r_gap <= '0;
        end else begin
            r_gap <= r_gap + GAP_W'(1);
        end
    end

    assign pix.wr_en      = r_wr_en;
    assign pix.wr_addr    = r_addr;
    assign pix.wr_data    = r_wr_data;
    assign pix.frame_done = r_frame_done;
    assign pix.rx_err     = r_rx_err;

endmodule

// File: doc/uart_pixel_loader.md
UART_PIXEL_LOADER -- requirements
Module: uart_pixel_loader

Interface
- REQ-001 SHALL have parameter CLK_FREQ, default 50000000, meaning system clock frequency in Hz.
- REQ-002 SHALL have parameter BAUD, default 115200, meaning UART bit rate; BAUD_DIV = CLK_FREQ/BAUD, integer-truncated.
- REQ-003 SHALL have parameter BYTES_PER_PIX, default 2, range 1..4, meaning UART bytes per pixel.
- REQ-004 SHALL have parameter H_PIX, default 480, meaning pixels per line.
- REQ-005 SHALL have parameter V_PIX, default 272, meaning lines per frame.
- REQ-006 SHALL have parameter GAP_BITS, default 32, meaning idle bit-times that abandon a partial pixel.
- REQ-007 SHALL have port Clk, input, 1 bit, meaning the single system clock.
- REQ-008 SHALL have port Reset, input, 1 bit, meaning synchronous, active-high reset.
- REQ-009 SHALL have port uart_rx, input, 1 bit, meaning asynchronous serial line, idle high.
- REQ-010 SHALL have port wr_en, output, 1 bit, meaning one-cycle RAM write strobe.
- REQ-011 SHALL have port wr_addr, output, ADDR_W bits, meaning RAM address; ADDR_W = clog2(H_PIX*V_PIX).
- REQ-012 SHALL have port wr_data, output, 8*BYTES_PER_PIX bits, meaning assembled pixel.
- REQ-013 SHALL have port frame_done, output, 1 bit, meaning one-cycle pulse when the last pixel of a frame is written.
- REQ-014 SHALL have port rx_err, output, 1 bit, meaning one-cycle pulse on a discarded byte.

Function
- REQ-015 SHALL pass uart_rx through a 2-FF synchronizer; all decoding uses the synchronized signal.
- REQ-016 SHALL implement RX FSM states IDLE, START, DATA, STOP; IDLE->START on a high-to-low edge.
- REQ-017 SHALL, in START, re-sample at BAUD_DIV/2; if high, return to IDLE with no rx_err (glitch reject).
- REQ-018 SHALL sample 8 data bits, LSB first, each BAUD_DIV cycles after the previous sample.
- REQ-019 SHALL, in STOP, sample the stop bit; low is a framing error: byte discarded, rx_err pulse, return to IDLE.
- REQ-020 SHALL shift each accepted byte into the pixel register; the first byte of a pixel is the most significant.
- REQ-021 SHALL assert wr_en for exactly one cycle, on the cycle after the stop-bit sample of byte BYTES_PER_PIX, with wr_data and wr_addr valid in that cycle.
- REQ-022 SHALL increment wr_addr after each write; after address H_PIX*V_PIX-1 it SHALL wrap to 0.
- REQ-023 SHALL assert frame_done in the same cycle as the wr_en of address H_PIX*V_PIX-1.
- REQ-024 SHALL, once GAP_BITS*BAUD_DIV cycles pass in IDLE with a partial pixel pending, clear the byte count; wr_addr is unchanged.
- REQ-025 SHALL NOT change wr_addr or the byte count when a byte is discarded.

Reset
- REQ-026 SHALL, when Reset is high at a Clk edge, drive wr_en=0, frame_done=0, rx_err=0, wr_addr=0, wr_data=0, byte count 0 and RX FSM IDLE.
- REQ-027 SHALL set the synchronizer flops to 1 (idle) on reset.
- REQ-028 SHALL discard a byte or pixel in progress when reset is applied mid-operation; no write occurs for it.

Configuration
- REQ-029 SHALL, with UART_PARITY_EN defined, expect an even-parity bit between data bit 7 and stop; a mismatch discards the byte and pulses rx_err.
- REQ-030 SHALL, without UART_PARITY_EN, use a 10-bit frame with no parity state and no parity logic.

Structure
- REQ-031 SHALL place the RX FSM state encoding and the clog2 helper function in shared package uart_tft_pkg.
- REQ-032 SHALL contain one sub-module, uart_byte_rx, covering the synchronizer, RX FSM and parity, with outputs byte_valid, byte_data and byte_err.

Verification
- REQ-033 SHALL be verified with CLK_FREQ=50000000, BAUD=5000000 (BAUD_DIV=10), H_PIX=4 and V_PIX=2 for all scenarios.
- REQ-034 Scenario: send 0x12 then 0x34 -> one wr_en with wr_data=0x1234 and wr_addr=0, 1 cycle after the second stop sample.
- REQ-035 Scenario: send 8 pixels -> addresses 0..7 written; frame_done coincides with address 7; the 9th pixel is written at address 0.
- REQ-036 Scenario: 0x12, then a 0x34 frame with a low stop bit, then 0x56 -> rx_err pulse once; wr_data=0x1256 at the next address.
- REQ-037 Scenario: 3-cycle low glitch on idle uart_rx -> no byte, no rx_err, no wr_en.
- REQ-038 Scenario: send 0xAB, idle 330 cycles, send 0xCD 0xEF -> wr_data=0xCDEF; 0xAB is dropped.
- REQ-039 Scenario: assert Reset midway through a second byte -> no wr_en and wr_addr=0; the next full pixel is written at address 0.
